// File: rtl/sdspi_card_responder.sv
// SPI-mode SD card model: decodes 48-bit command frames, answers R1/R3/R7 and streams
// 512-byte read blocks (pattern addr[7:0]+i) with CRC16, all paced by the host's sclk.
module sdspi_card_responder #(
  parameter int unsigned N_INIT    = 2,
  parameter int unsigned NAC_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        card_ready,
  output logic [31:0] cur_block_addr,
  output logic [31:0] blocks_sent,
  output logic [5:0]  last_cmd
);

  typedef enum logic [2:0] {StHunt, StResp, StNac, StToken, StData, StCrcHi, StCrcLo} state_e;

  localparam state_e      FirstDataSt = (NAC_BYTES == 0) ? StToken : StNac;
  localparam logic [15:0] NacLast     = 16'(NAC_BYTES - 1);

  logic [1:0]  cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic        sclk_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;
  logic [7:0]  tx_shift_q;
  logic        miso_q;
  logic [2:0]  frm_cnt_q;
  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  state_e      state_q;
  logic [39:0] resp_q;
  logic [2:0]  resp_len_q;
  logic        data_after_q, multi_q;
  logic [15:0] nac_cnt_q;
  logic [8:0]  byte_idx_q;
  logic [31:0] addr_q;
  logic [15:0] crc_q;
  logic        card_ready_q, app_flag_q;
  logic [15:0] acmd_cnt_q;
  logic [31:0] cur_block_addr_q, blocks_sent_q;
  logic [5:0]  last_cmd_q;

  logic        cs_s, sclk_s, mosi_s, rise, fall, byte_done, rx_active, frame_done, acmd_below;
  logic [7:0]  rx_byte, data_byte, idle_r1, other_r1;
  logic [39:0] resp_d;
  logic [2:0]  resp_len_d;
  logic        data_after_d, multi_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign cs_s       = cs_sync_q[1];
  assign sclk_s     = sclk_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign rise       = sclk_s & ~sclk_prev_q;
  assign fall       = ~sclk_s & sclk_prev_q;
  assign byte_done  = rise && (bit_cnt_q == 3'd7) && !cs_s;
  assign rx_byte    = {rx_shift_q, mosi_s};
  // The receiver listens in HUNT and throughout a CMD18 stream (for CMD12), never during a response.
  assign rx_active  = (state_q == StHunt) || (multi_q && state_q != StResp);
  assign frame_done = byte_done && rx_active && (frm_cnt_q == 3'd5);
  assign acmd_below = 32'(acmd_cnt_q) < N_INIT;
  assign data_byte  = addr_q[7:0] + byte_idx_q[7:0];
  assign idle_r1    = {7'b0, ~card_ready_q};
  assign other_r1   = card_ready_q ? 8'h04 : 8'h05;

  always_comb begin
    resp_d       = {other_r1, 32'h0};
    resp_len_d   = 3'd1;
    data_after_d = 1'b0;
    multi_d      = 1'b0;
    case (cmd_q)
      6'd0:  resp_d = {8'h01, 32'h0};
      6'd8: begin
        resp_d     = {idle_r1, 8'h00, 8'h00, 4'h0, arg_q[11:8], arg_q[7:0]};
        resp_len_d = 3'd5;
      end
      6'd55: resp_d = {idle_r1, 32'h0};
      6'd41: if (app_flag_q) resp_d = {(acmd_below ? 8'h01 : 8'h00), 32'h0};
      6'd58: begin
        resp_d     = {idle_r1, 32'hC0FF_8000};
        resp_len_d = 3'd5;
      end
      6'd17, 6'd18: begin
        if (card_ready_q) begin
          resp_d       = {8'h00, 32'h0};
          data_after_d = 1'b1;
          multi_d      = (cmd_q == 6'd18);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q        <= 2'b11;
      sclk_sync_q      <= 2'b00;
      mosi_sync_q      <= 2'b00;
      sclk_prev_q      <= 1'b0;
      bit_cnt_q        <= '0;
      rx_shift_q       <= '0;
      tx_shift_q       <= 8'hFF;
      miso_q           <= 1'b1;
      frm_cnt_q        <= '0;
      cmd_q            <= '0;
      arg_q            <= '0;
      state_q          <= StHunt;
      resp_q           <= '0;
      resp_len_q       <= '0;
      data_after_q     <= 1'b0;
      multi_q          <= 1'b0;
      nac_cnt_q        <= '0;
      byte_idx_q       <= '0;
      addr_q           <= '0;
      crc_q            <= '0;
      card_ready_q     <= 1'b0;
      app_flag_q       <= 1'b0;
      acmd_cnt_q       <= '0;
      cur_block_addr_q <= '0;
      blocks_sent_q    <= '0;
      last_cmd_q       <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs};
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_s;
      if (cs_s) begin
        bit_cnt_q  <= '0;
        tx_shift_q <= 8'hFF;
        miso_q     <= 1'b1;
        frm_cnt_q  <= '0;
        state_q    <= StHunt;
        multi_q    <= 1'b0;
      end else begin
        if (fall) begin
          miso_q     <= tx_shift_q[7];
          tx_shift_q <= {tx_shift_q[6:0], 1'b1};
        end
        if (rise) begin
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          rx_shift_q <= rx_byte[6:0];
        end
        if (byte_done) begin
          if (rx_active) begin
            if (frm_cnt_q == 3'd0) begin
              if (rx_byte[7:6] == 2'b01) begin
                cmd_q     <= rx_byte[5:0];
                frm_cnt_q <= 3'd1;
              end
            end else if (frm_cnt_q == 3'd5) begin
              frm_cnt_q <= 3'd0;
            end else begin
              arg_q     <= {arg_q[23:0], rx_byte};
              frm_cnt_q <= frm_cnt_q + 3'd1;
            end
          end
          tx_shift_q <= 8'hFF;
          if (frame_done && state_q == StHunt) begin
            last_cmd_q   <= cmd_q;
            resp_q       <= resp_d;
            resp_len_q   <= resp_len_d;
            data_after_q <= data_after_d;
            multi_q      <= multi_d;
            addr_q       <= arg_q;
            state_q      <= StResp;
            app_flag_q   <= (cmd_q == 6'd55);
            if (cmd_q == 6'd0) begin
              card_ready_q <= 1'b0;
              acmd_cnt_q   <= '0;
            end
            if (cmd_q == 6'd41 && app_flag_q) begin
              if (acmd_below) acmd_cnt_q <= acmd_cnt_q + 16'd1;
              else            card_ready_q <= 1'b1;
            end
          end else if (frame_done && cmd_q == 6'd12) begin
            // Stream abort: this boundary carries the stuff byte, R1 follows.
            last_cmd_q   <= cmd_q;
            resp_q       <= {8'h00, 32'h0};
            resp_len_q   <= 3'd1;
            data_after_q <= 1'b0;
            multi_q      <= 1'b0;
            app_flag_q   <= 1'b0;
            state_q      <= StResp;
          end else begin
            unique case (state_q)
              StHunt: ;
              StResp: begin
                tx_shift_q <= resp_q[39:32];
                resp_q     <= {resp_q[31:0], 8'h00};
                resp_len_q <= resp_len_q - 3'd1;
                nac_cnt_q  <= '0;
                if (resp_len_q == 3'd1) state_q <= data_after_q ? FirstDataSt : StHunt;
              end
              StNac: begin
                nac_cnt_q <= nac_cnt_q + 16'd1;
                if (nac_cnt_q == NacLast) state_q <= StToken;
              end
              StToken: begin
                tx_shift_q       <= 8'hFE;
                cur_block_addr_q <= addr_q;
                crc_q            <= '0;
                byte_idx_q       <= '0;
                state_q          <= StData;
              end
              StData: begin
                tx_shift_q <= data_byte;
                crc_q      <= crc16_byte(crc_q, data_byte);
                byte_idx_q <= byte_idx_q + 9'd1;
                if (byte_idx_q == 9'd511) state_q <= StCrcHi;
              end
              StCrcHi: begin
                tx_shift_q <= crc_q[15:8];
                state_q    <= StCrcLo;
              end
              StCrcLo: begin
                tx_shift_q    <= crc_q[7:0];
                blocks_sent_q <= blocks_sent_q + 32'd1;
                nac_cnt_q     <= '0;
                if (multi_q) begin
                  addr_q  <= addr_q + 32'd1;
                  state_q <= FirstDataSt;
                end else begin
                  state_q <= StHunt;
                end
              end
              default: state_q <= StHunt;
            endcase
          end
        end
      end
    end
  end

  assign miso           = miso_q;
  assign card_ready     = card_ready_q;
  assign cur_block_addr = cur_block_addr_q;
  assign blocks_sent    = blocks_sent_q;
  assign last_cmd       = last_cmd_q;

endmodule

// File: tb/tb_sdspi_card_responder.sv
// Directed closed-loop bench: acts as the SPI host, clocks command frames in and checks
// every response, data and CRC byte against hand-derived values and a CRC16 model.
module tb_sdspi_card_responder;

  logic        clk = 1'b0;
  logic        rst, cs, sclk, mosi;
  logic        miso, card_ready;
  logic [31:0] cur_block_addr, blocks_sent;
  logic [5:0]  last_cmd;

  int n_vec = 0;
  int n_err = 0;

  sdspi_card_responder #(
    .N_INIT   (2),
    .NAC_BYTES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cs            (cs),
    .sclk          (sclk),
    .mosi          (mosi),
    .miso          (miso),
    .card_ready    (card_ready),
    .cur_block_addr(cur_block_addr),
    .blocks_sent   (blocks_sent),
    .last_cmd      (last_cmd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Byte-wise CCITT form (data XORed into the high byte, then 8 shifts).
  function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // Mode 0 host: 4 clk low (miso sampled at its end), 4 clk high per bit.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    spi_byte(8'hFF, rx);
    check_eq(tag, {24'h0, rx}, {24'h0, exp});
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] rx;
    logic [7:0] crc;
    crc = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF;
    spi_byte({2'b01, idx}, rx);
    for (int b = 3; b >= 0; b--) spi_byte(arg[8*b +: 8], rx);
    spi_byte(crc, rx);
  endtask

  task automatic init_card();
    for (int k = 0; k < 3; k++) begin
      send_cmd(6'd55, 32'h0);
      expect_byte("cmd55_ncr", 8'hFF);
      expect_byte("cmd55_r1", 8'h01);
      send_cmd(6'd41, 32'h4000_0000);
      expect_byte("acmd41_ncr", 8'hFF);
      expect_byte("acmd41_r1", (k < 2) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic read_block(input logic [31:0] addr);
    logic [15:0] crc;
    logic [7:0]  d;
    crc = 16'h0000;
    for (int k = 0; k < 4; k++) expect_byte("nac", 8'hFF);
    expect_byte("token", 8'hFE);
    for (int i = 0; i < 512; i++) begin
      d = addr[7:0] + 8'(i);
      expect_byte("data", d);
      crc = crc_model(crc, d);
    end
    expect_byte("crc_hi", crc[15:8]);
    expect_byte("crc_lo", crc[7:0]);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [7:0]  cmd12 [6];
    cmd12[0] = 8'h4C; cmd12[1] = 8'h00; cmd12[2] = 8'h00;
    cmd12[3] = 8'h00; cmd12[4] = 8'h00; cmd12[5] = 8'h61;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_miso", {31'h0, miso}, 32'h1);
    check_eq("rst_ready", {31'h0, card_ready}, 32'h0);
    check_eq("rst_addr", cur_block_addr, 32'h0);
    check_eq("rst_blocks", blocks_sent, 32'h0);
    check_eq("rst_last_cmd", {26'h0, last_cmd}, 32'h0);

    cs = 1'b0;
    repeat (4) @(negedge clk);

    // Read before init: error R1, no data token.
    send_cmd(6'd17, 32'h0);
    expect_byte("cmd17_idle_ncr", 8'hFF);
    expect_byte("cmd17_idle_r1", 8'h05);
    expect_byte("cmd17_idle_no_token", 8'hFF);
    expect_byte("cmd17_idle_no_token", 8'hFF);
    check_eq("cmd17_idle_last", {26'h0, last_cmd}, 32'd17);

    send_cmd(6'd0, 32'h0);
    expect_byte("cmd0_ncr", 8'hFF);
    expect_byte("cmd0_r1", 8'h01);
    check_eq("cmd0_ready", {31'h0, card_ready}, 32'h0);

    send_cmd(6'd8, 32'h0000_01AA);
    expect_byte("cmd8_ncr", 8'hFF);
    expect_byte("cmd8_r1", 8'h01);
    expect_byte("cmd8_b1", 8'h00);
    expect_byte("cmd8_b2", 8'h00);
    expect_byte("cmd8_vhs", 8'h01);
    expect_byte("cmd8_pat", 8'hAA);

    init_card();
    check_eq("init_ready", {31'h0, card_ready}, 32'h1);

    send_cmd(6'd58, 32'h0);
    expect_byte("cmd58_ncr", 8'hFF);
    expect_byte("cmd58_r1", 8'h00);
    expect_byte("ocr3", 8'hC0);
    expect_byte("ocr2", 8'hFF);
    expect_byte("ocr1", 8'h80);
    expect_byte("ocr0", 8'h00);

    // Single block at 0x10: pattern wraps 0xFF -> 0x00 inside the block.
    send_cmd(6'd17, 32'h10);
    expect_byte("cmd17_ncr", 8'hFF);
    expect_byte("cmd17_r1", 8'h00);
    read_block(32'h10);
    expect_byte("cmd17_after", 8'hFF);
    check_eq("cmd17_blocks", blocks_sent, 32'd1);
    check_eq("cmd17_addr", cur_block_addr, 32'h10);
    check_eq("cmd17_last", {26'h0, last_cmd}, 32'd17);

    send_cmd(6'd24, 32'h0);
    expect_byte("cmd24_ncr", 8'hFF);
    expect_byte("cmd24_r1", 8'h04);
    check_eq("cmd24_last", {26'h0, last_cmd}, 32'd24);

    // Multi-block from the top address: next block wraps to 0, CMD12 lands inside it.
    send_cmd(6'd18, 32'hFFFF_FFFF);
    expect_byte("cmd18_ncr", 8'hFF);
    expect_byte("cmd18_r1", 8'h00);
    read_block(32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) expect_byte("nac2", 8'hFF);
    expect_byte("token2", 8'hFE);
    check_eq("cmd18_addr_wrap", cur_block_addr, 32'h0);
    for (int i = 0; i < 10; i++) expect_byte("data2", 8'(i));
    for (int k = 0; k < 6; k++) begin
      spi_byte(cmd12[k], rx);
      check_eq("data2_during_cmd12", {24'h0, rx}, 32'(10 + k));
    end
    expect_byte("cmd12_stuff", 8'hFF);
    expect_byte("cmd12_r1", 8'h00);
    expect_byte("cmd12_after", 8'hFF);
    check_eq("cmd18_blocks", blocks_sent, 32'd2);
    check_eq("cmd12_last", {26'h0, last_cmd}, 32'd12);

    // cs abort inside a block: data byte 4 = 0x24, so miso holds its MSB (0) before the abort.
    send_cmd(6'd17, 32'h20);
    expect_byte("cs_ncr", 8'hFF);
    expect_byte("cs_r1", 8'h00);
    for (int k = 0; k < 4; k++) expect_byte("cs_nac", 8'hFF);
    expect_byte("cs_token", 8'hFE);
    for (int i = 0; i < 4; i++) expect_byte("cs_data", 8'h20 + 8'(i));
    repeat (4) @(negedge clk);
    check_eq("cs_miso_before", {31'h0, miso}, 32'h0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("cs_miso_idle", {31'h0, miso}, 32'h1);
    check_eq("cs_ready_kept", {31'h0, card_ready}, 32'h1);
    check_eq("cs_blocks_kept", blocks_sent, 32'd2);
    check_eq("cs_addr", cur_block_addr, 32'h20);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(6'd0, 32'h0);
    expect_byte("cs_cmd0_ncr", 8'hFF);
    expect_byte("cs_cmd0_r1", 8'h01);
    check_eq("cs_cmd0_ready", {31'h0, card_ready}, 32'h0);

    // Synchronous reset in the middle of a stream.
    init_card();
    send_cmd(6'd18, 32'h5);
    expect_byte("rst18_ncr", 8'hFF);
    expect_byte("rst18_r1", 8'h00);
    for (int k = 0; k < 4; k++) expect_byte("rst18_nac", 8'hFF);
    expect_byte("rst18_token", 8'hFE);
    expect_byte("rst18_d0", 8'h05);
    expect_byte("rst18_d1", 8'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst2_miso", {31'h0, miso}, 32'h1);
    check_eq("rst2_ready", {31'h0, card_ready}, 32'h0);
    check_eq("rst2_addr", cur_block_addr, 32'h0);
    check_eq("rst2_blocks", blocks_sent, 32'h0);
    check_eq("rst2_last_cmd", {26'h0, last_cmd}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
